mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, 4: number of consecutive fetch losses after which fetch wins the next arbitration; range 1..15.
REQ-002 Parameter TIMEOUT_CYCLES, 64: number of response-wait cycles before a timeout; used only with MEM_ARB_TIMEOUT_EN.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Ports if_req (in, 1), if_addr (in, 32), if_gnt (out, 1), if_rvalid (out, 1), if_rdata (out, 32): instruction-fetch requester; read-only.
REQ-006 Ports dm_req (in, 1), dm_we (in, 1), dm_be (in, 4), dm_addr (in, 32), dm_wdata (in, 32), dm_gnt (out, 1), dm_rvalid (out, 1), dm_rdata (out, 32): data-memory requester.
REQ-007 Ports mem_req, mem_we (out, 1 each), mem_be (out, 4), mem_addr, mem_wdata (out, 32 each), mem_gnt, mem_rvalid (in, 1 each), mem_rdata (in, 32): shared memory port.
REQ-008 Ports arb_busy (out, 1): state is not IDLE; arb_err (out, 1): timeout pulse.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, REQ, RESP; at most one transaction is outstanding.
REQ-010 IDLE, any request present: data wins unless if_req=1 and starve_cnt==STARVE_LIMIT, in which case fetch wins; the winner's fields are latched into registered mem_* outputs, mem_req=1, owner recorded; next state REQ.
REQ-011 REQ: mem_req and all mem_* fields SHALL stay stable until mem_gnt=1; in that cycle the owner's gnt SHALL be 1 (combinational from mem_gnt) and the next state SHALL be RESP, with mem_req=0 from the next cycle.
REQ-012 Requesters hold req and fields stable until their gnt; the non-owner's gnt SHALL stay 0.
REQ-013 RESP: on mem_rvalid=1, the owner's rvalid SHALL pulse for one cycle carrying mem_rdata; the next state SHALL be IDLE. Writes are acknowledged the same way.
REQ-014 if_rdata and dm_rdata SHALL be 0 whenever their rvalid is 0.
REQ-015 mem_rvalid in IDLE or REQ SHALL be ignored.
REQ-016 Minimum transaction time: 3 cycles (IDLE arbitration, REQ with immediate gnt, RESP with immediate rvalid); arbitration resumes in the cycle after rvalid.
REQ-017 Starvation counter (4-bit): saturating increment at any arbitration where if_req=1 and data wins; cleared when fetch wins, or when if_req=0 at arbitration.
REQ-018 A simultaneous if_req and dm_req with starve_cnt<STARVE_LIMIT SHALL grant data; fetch SHALL be served no later than the (STARVE_LIMIT+1)th arbitration.

Reset
REQ-019 Asserting rst SHALL, without waiting for a clock edge: set the state to IDLE, clear starve_cnt, owner, and every output to 0, and drop any outstanding transaction.
REQ-020 After reset is released mid-transaction, a late mem_rvalid SHALL be ignored.

Configuration
REQ-021 With MEM_ARB_TIMEOUT_EN defined: TIMEOUT_CYCLES consecutive RESP cycles without mem_rvalid SHALL pulse arb_err and the owner's rvalid (rdata 0) for one cycle, then go to IDLE.
REQ-022 Without MEM_ARB_TIMEOUT_EN: arb_err SHALL be tied to 0 and RESP SHALL wait indefinitely; the port list is identical in both builds.

Structure
REQ-023 The shared core_pkg SHALL hold the arbiter state enum (IDLE/REQ/RESP), owner encoding (OWN_IF/OWN_DM), and the XLEN=32 and byte-enable width constants.
REQ-024 One sub-module, mem_arb_timer (response timeout counter), SHALL be instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-025 Scenario: if_req only, addr 0x100, mem_gnt immediate, rvalid the next cycle with 0x00500293 -> if_gnt in cycle 2, if_rvalid with if_rdata=0x00500293 in cycle 3, dm_* outputs stay 0.
REQ-026 Scenario: if_req and dm_req held high continuously (dm store, be=4'b1111, addr 0x200, wdata 0xCAFEF00D), STARVE_LIMIT=4 -> four data grants, then one fetch grant, pattern repeats.
REQ-027 Scenario: mem_gnt delayed 3 cycles -> mem_req and mem_addr stable across all three cycles, a single owner gnt pulse.
REQ-028 Scenario: rst asserted during RESP, released, then a stray mem_rvalid -> no rvalid on either requester, arb_busy=0.
REQ-029 Scenario (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): no mem_rvalid after grant -> arb_err and owner rvalid with rdata 0 on the 8th RESP cycle, then IDLE.
REQ-030 Scenario: mem_rvalid pulsed while in REQ -> no rvalid forwarded, state unchanged.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: arbiter state, owner encoding and bus widths.
// Imported by the memory-port arbiter and its response timer.
package core_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Response timeout counter for the memory-port arbiter.
// expired is high in the TIMEOUT_CYCLES-th consecutive cycle of run.
module mem_arb_timer
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Count consecutive run cycles; restart whenever run drops or fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one shared memory port, one txn in flight.
// Optional response timeout: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        arb_busy,
  output logic        arb_err
);

  arb_state_t state;
  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       fetch_wins;
  logic       timeout;
  logic       in_req;
  logic       in_resp;
  logic       resp_done;

  assign fetch_wins =
    if_req && (!dm_req || starve_cnt == 4'(STARVE_LIMIT));

  assign in_req    = (state == REQ);
  assign in_resp   = (state == RESP);
  assign resp_done = in_resp && (mem_rvalid || timeout);
  assign arb_busy  = (state != IDLE);

  assign if_gnt = in_req && mem_gnt && owner == OWN_IF;
  assign dm_gnt = in_req && mem_gnt && owner == OWN_DM;

  assign if_rvalid = resp_done && owner == OWN_IF;
  assign dm_rvalid = resp_done && owner == OWN_DM;

  // A timeout completion carries no data, so rdata gates on mem_rvalid.
  assign if_rdata =
    (in_resp && mem_rvalid && owner == OWN_IF) ? mem_rdata : '0;
  assign dm_rdata =
    (in_resp && mem_rvalid && owner == OWN_DM) ? mem_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  logic expired;

  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (in_resp && !mem_rvalid),
    .expired(expired)
  );

  assign timeout = expired;
  assign arb_err = expired;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign arb_err = 1'b0;
`endif

  // Arbitration, request hold and response wait; mem_* are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            state   <= REQ;
            mem_req <= 1'b1;
            if (fetch_wins) begin
              owner      <= OWN_IF;
              mem_we     <= 1'b0;
              mem_be     <= '1;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end else begin
              owner     <= OWN_DM;
              mem_we    <= dm_we;
              mem_be    <= dm_be;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              if (!if_req) begin
                starve_cnt <= '0;
              end else if (starve_cnt != 4'hf) begin
                starve_cnt <= starve_cnt + 4'd1;
              end
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state   <= RESP;
            mem_req <= 1'b0;
          end
        end
        RESP: begin
          if (mem_rvalid || timeout) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter.
// Build with MEM_ARB_TIMEOUT_EN to exercise the timeout path.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        arb_busy, arb_err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit          dm;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  mem_port_arbiter #(
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_be     (dm_be),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .arb_busy  (arb_busy),
    .arb_err   (arb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_busy"}, arb_busy, 0);
    chk({tag, "_err"}, arb_err, 0);
    chk({tag, "_if_gnt"}, if_gnt, 0);
    chk({tag, "_dm_gnt"}, dm_gnt, 0);
    chk({tag, "_if_rv"}, if_rvalid, 0);
    chk({tag, "_dm_rv"}, dm_rvalid, 0);
  endtask

  // Acts as the memory for one transaction; pops the expected owner.
  task automatic serve(input int gnt_dly, input int rv_dly,
                       input bit drop, input bit stray);
    exp_t e;
    int   w;
    w = 0;
    tick();
    while (!mem_req && w < 20) begin
      tick();
      w++;
    end
    chk("req_seen", mem_req, 1);
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk("addr", mem_addr, e.addr);
    chk("we", mem_we, e.we);
    if (e.dm) begin
      chk("be", mem_be, e.be);
      chk("wdata", mem_wdata, e.wdata);
    end
    for (int i = 0; i < gnt_dly; i++) begin
      mem_gnt    = 1'b0;
      mem_rvalid = stray;
      mem_rdata  = 32'hbad0_0000 + i;
      #1;
      chk("wait_req", mem_req, 1);
      chk("wait_addr", mem_addr, e.addr);
      chk("wait_if_gnt", if_gnt, 0);
      chk("wait_dm_gnt", dm_gnt, 0);
      chk("wait_if_rv", if_rvalid, 0);
      chk("wait_dm_rv", dm_rvalid, 0);
      chk("wait_if_rd", if_rdata, 0);
      chk("wait_busy", arb_busy, 1);
      tick();
      mem_rvalid = 1'b0;
    end
    mem_gnt = 1'b1;
    #1;
    chk("gnt_req", mem_req, 1);
    chk("gnt_addr", mem_addr, e.addr);
    chk("if_gnt", if_gnt, !e.dm);
    chk("dm_gnt", dm_gnt, e.dm);
    if (drop) begin
      if (e.dm) dm_req = 1'b0;
      else if_req = 1'b0;
    end
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < rv_dly; i++) begin
      #1;
      chk("resp_req", mem_req, 0);
      chk("resp_if_gnt", if_gnt, 0);
      chk("resp_dm_gnt", dm_gnt, 0);
      chk("resp_if_rv", if_rvalid, 0);
      chk("resp_dm_rv", dm_rvalid, 0);
      chk("resp_busy", arb_busy, 1);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = e.rdata;
    #1;
    chk("rv_mem_req", mem_req, 0);
    chk("if_rvalid", if_rvalid, !e.dm);
    chk("dm_rvalid", dm_rvalid, e.dm);
    chk("if_rdata", if_rdata, e.dm ? 32'h0 : e.rdata);
    chk("dm_rdata", dm_rdata, e.dm ? e.rdata : 32'h0);
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h5a5a_a5a5;
    #1;
    chk("post_busy", arb_busy, 0);
    chk("post_if_rv", if_rvalid, 0);
    chk("post_dm_rv", dm_rvalid, 0);
    chk("post_if_rd", if_rdata, 0);
    chk("post_dm_rd", dm_rdata, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;

    // Asynchronous reset with no clock edge involved.
    #2;
    rst = 1'b1;
    #1;
    idle_outs("rst");
    tick();
    tick();
    rst = 1'b0;
    tick();
    idle_outs("post_rst");

    // Single fetch: grant in cycle 2, data in cycle 3.
    if_req  = 1'b1;
    if_addr = 32'h100;
    e = '{dm: 0, addr: 32'h100, we: 0, be: 4'hf, wdata: 0,
          rdata: 32'h0050_0293};
    sb.push_back(e);
    serve(0, 0, 1, 0);

    // Both held: four data grants, then one fetch grant, twice.
    do_reset();
    if_req   = 1'b1;
    if_addr  = 32'h300;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_be    = 4'b1111;
    dm_addr  = 32'h200;
    dm_wdata = 32'hcafe_f00d;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) begin
        e.dm    = (k != 4);
        e.addr  = e.dm ? 32'h200 : 32'h300;
        e.we    = e.dm;
        e.be    = 4'hf;
        e.wdata = 32'hcafe_f00d;
        e.rdata = 32'h1000 + 32'(r * 5 + k);
        sb.push_back(e);
        serve(0, 0, 0, 0);
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;

    // Delayed grant: request fields hold for three cycles.
    tick();
    dm_req   = 1'b1;
    dm_we    = 1'b0;
    dm_be    = 4'b0011;
    dm_addr  = 32'h40;
    dm_wdata = 32'h0;
    e = '{dm: 1, addr: 32'h40, we: 0, be: 4'b0011, wdata: 0,
          rdata: 32'h1234_5678};
    sb.push_back(e);
    serve(3, 1, 1, 0);

    // Stray mem_rvalid in REQ must not be forwarded.
    tick();
    if_req  = 1'b1;
    if_addr = 32'h404;
    e = '{dm: 0, addr: 32'h404, we: 0, be: 4'hf, wdata: 0,
          rdata: 32'hfeed_beef};
    sb.push_back(e);
    serve(2, 0, 1, 1);

    // Reset during RESP, then a late mem_rvalid.
    tick();
    if_req  = 1'b1;
    if_addr = 32'h500;
    tick();
    mem_gnt = 1'b1;
    #1;
    chk("rr_if_gnt", if_gnt, 1);
    if_req = 1'b0;
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("rr_busy_resp", arb_busy, 1);
    rst = 1'b1;
    #1;
    idle_outs("rr_async");
    tick();
    tick();
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hdead_beef;
    #1;
    chk("rr_if_rv", if_rvalid, 0);
    chk("rr_dm_rv", dm_rvalid, 0);
    chk("rr_if_rd", if_rdata, 0);
    chk("rr_busy", arb_busy, 0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("rr_busy2", arb_busy, 0);

    // No response after grant.
    tick();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h80;
    tick();
    mem_gnt = 1'b1;
    #1;
    chk("to_dm_gnt", dm_gnt, 1);
    dm_req = 1'b0;
    tick();
    mem_gnt = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (k < 8) begin
        chk("to_err_early", arb_err, 0);
        chk("to_rv_early", dm_rvalid, 0);
        chk("to_busy", arb_busy, 1);
      end else begin
        chk("to_err", arb_err, 1);
        chk("to_dm_rv", dm_rvalid, 1);
        chk("to_dm_rd", dm_rdata, 0);
        chk("to_if_rv", if_rvalid, 0);
      end
      tick();
    end
    #1;
    chk("to_idle", arb_busy, 0);
    chk("to_err_clr", arb_err, 0);
    chk("to_rv_clr", dm_rvalid, 0);
`else
    for (int k = 1; k <= 20; k++) begin
      #1;
      chk("nt_err", arb_err, 0);
      chk("nt_rv", dm_rvalid, 0);
      chk("nt_busy", arb_busy, 1);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0077;
    #1;
    chk("nt_dm_rv", dm_rvalid, 1);
    chk("nt_dm_rd", dm_rdata, 32'h77);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("nt_idle", arb_busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
